ms_sync_gen: RTL
================

// Module: ms_sync_gen
// PURPOSE
//  Consumes the 1 ms tick from the system interval timer and generates the SimuCam
//  synchronisation pulse train: one master sync followed by N-1 normal syncs per cycle.
//  Sits directly downstream of the 1 ms timer; tick_in is wired to the timer's irq line.
//  Avalon-MM 16-bit slave for the Nios II. sync_out/master_sync_out drive the FEE/channel logic.
// PARAMETERS
//  DEF_PERIOD_MS   6250  reset value of sync period, ms
//  DEF_PULSE_MS    200   reset value of sync high width, ms
//  DEF_N_PULSES    4     reset value of syncs per cycle (master + N-1 normal), 1..15
// PORTS
//  clk              in   1   system clock, 50 MHz
//  reset_n          in   1   asynchronous, active-low reset
//  tick_in          in   1   1 ms tick, level; only its rising edge is used
//  address          in   3   Avalon register address
//  chipselect       in   1   Avalon chip select
//  write_n          in   1   Avalon write, active-low
//  writedata        in   16  Avalon write data
//  readdata         out  16  Avalon read data, registered
//  sync_out         out  1   sync pulse, high for pulse_ms
//  master_sync_out  out  1   high together with sync_out on pulse index 0 only
//  irq              out  1   sync_event & irq_en
// BEHAVIOUR
//  Register map:
//   0 STATUS   bit0 running (RO), bit1 sync_event (any write clears)
//   1 CONTROL  bit0 start (W1, self-clear), bit1 stop (W1, self-clear),
//              bit2 irq_en (R/W), bit3 one_shot (R/W)
//   2 PERIOD   period_ms[15:0]
//   3 PULSE    pulse_ms[15:0]
//   4 NPULSE   n_pulses[3:0]
//   5/6 TS_L/TS_H  see CONFIGURATION
//  - Reset: every output 0; registers at their DEF_*; FSM in IDLE; all counters 0.
//  - Tick edge: tick_rise = tick_in & ~tick_d (registered). A tick held high counts once.
//  - FSM states:
//     IDLE  -> start            : PULSE; ms_cnt=0, idx=0, shadows loaded
//     PULSE -> tick_rise, ms_cnt==eff_pulse-1  : GAP; sync_out falls
//     GAP   -> tick_rise, ms_cnt==eff_period-1 : ms_cnt=0, idx=(idx==eff_n-1)?0:idx+1;
//              wrap with one_shot -> IDLE, else -> PULSE with shadows reloaded
//     any   -> stop             : IDLE
//  - Outputs are registered.
//    - sync_out is 1 in PULSE.
//    - master_sync_out = sync_out & (idx==0).
//    - Both outputs rise the cycle after entry to PULSE.
//  - ms_cnt increments on each tick_rise in PULSE/GAP and holds otherwise.
//  - Shadowing: PERIOD/PULSE/NPULSE writes take effect only at the next PULSE entry;
//    they never retime a cycle in progress.
//  - Clamps, computed at shadow load:
//    - eff_period = max(period_ms, 2)
//    - eff_pulse = min(max(pulse_ms, 1), eff_period-1)
//    - eff_n = max(n_pulses, 1)
//  - sync_event sets on every PULSE entry. If set and clear coincide, set wins.
//  - Start while running restarts the cycle: ms_cnt=0, idx=0.
//  - Start and stop in the same write: stop wins.
//  - Stop takes effect the next cycle; outputs fall the cycle after.
//  - readdata: 1-cycle latency; unmapped addresses read 0; reserved bits read 0.
//  - Reset asserted mid-pulse: outputs drop asynchronously; no residual pulse after release.
// CONFIGURATION
//  MS_SYNC_TIMESTAMP_EN
//   - defined:
//     - 32-bit ms_timestamp increments on every tick_rise regardless of FSM state; wraps 2^32-1 -> 0.
//     - Reading TS_L returns [15:0] and latches [31:16] into a shadow.
//     - Reading TS_H returns that shadow, giving coherent pairs.
//     - Writing either address zeroes the counter.
//   - undefined: no counter or shadow; addresses 5/6 read 0 and writes are ignored.
// STRUCTURE
//  - Package ms_sync_pkg: FSM state enum, register address localparams,
//    CONTROL/STATUS bit indices, reset defaults.
//  - Sub-module ms_sync_regs: Avalon decode, register file, start/stop strobes,
//    readdata mux, and the timestamp shadow.
//  - The top level holds tick edge detect, shadows, FSM and counters.
// TESTING
//  - Defaults, start, 1 tick per 50 clk:
//    sync_out high 200 ticks, period 6250 ticks;
//    master only on pulses 1, 5, 9; irq stays 0.
//  - PERIOD=10, PULSE=3, NPULSE=2, irq_en=1, one_shot=1, start:
//    exactly 2 pulses, 3 ms high / 7 ms low, master on the first only;
//    irq asserts per pulse start; then running=0.
//  - PULSE=0 -> 1 ms high. PULSE=20 with PERIOD=10 -> 9 ms high.
//    NPULSE=0 -> every pulse is master.
//  - Write PERIOD=5 mid-GAP: current cycle keeps its old period; the next cycle uses 5.
//  - Single write CONTROL=0x3: stays/returns IDLE.
//    Status clear on the same clk as a pulse entry: sync_event=1.
//    Reset mid-PULSE: outputs 0 immediately.
//  - With MS_SYNC_TIMESTAMP_EN:
//    - preload near 0x0000FFFF via ticks, read TS_L then TS_H across the carry -> coherent value;
//    - write TS_L -> reads 0.
//    - Without the macro: reads 0.

Source files
------------

// File: rtl/ms_sync_pkg.sv
// rtl/ms_sync_pkg.sv - FSM states, register map, bit indices and reset defaults for ms_sync_gen
package ms_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } sync_state_e;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIOD  = 3'd2;
  localparam logic [2:0] ADDR_PULSE   = 3'd3;
  localparam logic [2:0] ADDR_NPULSE  = 3'd4;
  localparam logic [2:0] ADDR_TS_L    = 3'd5;
  localparam logic [2:0] ADDR_TS_H    = 3'd6;

  localparam int STAT_RUNNING  = 0;
  localparam int STAT_EVENT    = 1;
  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_ONE_SHOT = 3;

  localparam logic [15:0] DEFAULT_PERIOD_MS = 16'd6250;
  localparam logic [15:0] DEFAULT_PULSE_MS  = 16'd200;
  localparam logic [3:0]  DEFAULT_N_PULSES  = 4'd4;

  function automatic logic [15:0] clamp_period(input logic [15:0] period);
    return (period < 16'd2) ? 16'd2 : period;
  endfunction

  // The pulse must leave at least one low millisecond in every period.
  function automatic logic [15:0] clamp_pulse(input logic [15:0] pulse, input logic [15:0] eff_period);
    logic [15:0] width;
    width = (pulse == 16'd0) ? 16'd1 : pulse;
    return (width > eff_period - 16'd1) ? eff_period - 16'd1 : width;
  endfunction

  function automatic logic [3:0] clamp_n(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/ms_sync_regs.sv
// rtl/ms_sync_regs.sv - Avalon-MM register file, start/stop strobes and readdata mux
// MS_SYNC_TIMESTAMP_EN adds the free-running ms timestamp with its coherent high-half shadow.
module ms_sync_regs
  import ms_sync_pkg::*;
#(
  parameter logic [15:0] DEF_PERIOD_MS = DEFAULT_PERIOD_MS,
  parameter logic [15:0] DEF_PULSE_MS  = DEFAULT_PULSE_MS,
  parameter logic [3:0]  DEF_N_PULSES  = DEFAULT_N_PULSES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        running,
  input  logic        pulse_entry,
  input  logic        tick_rise,
  output logic        start_stb,
  output logic        stop_stb,
  output logic [15:0] period_ms,
  output logic [15:0] pulse_ms,
  output logic [3:0]  n_pulses,
  output logic        one_shot,
  output logic        irq
);

  logic        wr_en;
  logic        rd_en;
  logic [15:0] period_q, period_d;
  logic [15:0] pulse_q, pulse_d;
  logic [3:0]  npulse_q, npulse_d;
  logic        irq_en_q, irq_en_d;
  logic        one_shot_q, one_shot_d;
  logic        event_q, event_d;
  logic [15:0] readdata_q, readdata_d;
  logic [15:0] ts_lo;
  logic [15:0] ts_hi;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;

  assign start_stb = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_START];
  assign stop_stb  = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_STOP];

  always_comb begin
    period_d   = period_q;
    pulse_d    = pulse_q;
    npulse_d   = npulse_q;
    irq_en_d   = irq_en_q;
    one_shot_d = one_shot_q;
    event_d    = event_q;
    if (wr_en) begin
      case (address)
        ADDR_STATUS:  event_d = 1'b0;
        ADDR_CONTROL: begin
          irq_en_d   = writedata[CTRL_IRQ_EN];
          one_shot_d = writedata[CTRL_ONE_SHOT];
        end
        ADDR_PERIOD:  period_d = writedata;
        ADDR_PULSE:   pulse_d  = writedata;
        ADDR_NPULSE:  npulse_d = writedata[3:0];
        default: ;
      endcase
    end
    // A pulse entry in the same cycle as a STATUS write must not be lost.
    if (pulse_entry) event_d = 1'b1;
  end

  always_comb begin
    readdata_d = 16'h0000;
    if (rd_en) begin
      case (address)
        ADDR_STATUS: begin
          readdata_d[STAT_RUNNING] = running;
          readdata_d[STAT_EVENT]   = event_q;
        end
        ADDR_CONTROL: begin
          readdata_d[CTRL_IRQ_EN]   = irq_en_q;
          readdata_d[CTRL_ONE_SHOT] = one_shot_q;
        end
        ADDR_PERIOD: readdata_d = period_q;
        ADDR_PULSE:  readdata_d = pulse_q;
        ADDR_NPULSE: readdata_d = {12'h000, npulse_q};
        ADDR_TS_L:   readdata_d = ts_lo;
        ADDR_TS_H:   readdata_d = ts_hi;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= DEF_PERIOD_MS;
      pulse_q    <= DEF_PULSE_MS;
      npulse_q   <= DEF_N_PULSES;
      irq_en_q   <= 1'b0;
      one_shot_q <= 1'b0;
      event_q    <= 1'b0;
      readdata_q <= 16'h0000;
    end else begin
      period_q   <= period_d;
      pulse_q    <= pulse_d;
      npulse_q   <= npulse_d;
      irq_en_q   <= irq_en_d;
      one_shot_q <= one_shot_d;
      event_q    <= event_d;
      readdata_q <= readdata_d;
    end
  end

`ifdef MS_SYNC_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  logic [15:0] ts_hi_q, ts_hi_d;

  // Reading the low half freezes the high half so a TS_L/TS_H pair is coherent.
  always_comb begin
    ts_d    = ts_q;
    ts_hi_d = ts_hi_q;
    if (tick_rise) ts_d = ts_q + 32'd1;
    if (wr_en && ((address == ADDR_TS_L) || (address == ADDR_TS_H))) ts_d = 32'd0;
    if (rd_en && (address == ADDR_TS_L)) ts_hi_d = ts_q[31:16];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q    <= 32'd0;
      ts_hi_q <= 16'h0000;
    end else begin
      ts_q    <= ts_d;
      ts_hi_q <= ts_hi_d;
    end
  end

  assign ts_lo = ts_q[15:0];
  assign ts_hi = ts_hi_q;
`else
  logic ts_unused;
  assign ts_unused = tick_rise;
  assign ts_lo     = 16'h0000;
  assign ts_hi     = 16'h0000;
`endif

  assign readdata  = readdata_q;
  assign period_ms = period_q;
  assign pulse_ms  = pulse_q;
  assign n_pulses  = npulse_q;
  assign one_shot  = one_shot_q;
  assign irq       = event_q & irq_en_q;

endmodule

// File: rtl/ms_sync_gen.sv
// rtl/ms_sync_gen.sv - SimuCam sync pulse generator driven by the 1 ms timer tick
// Timestamp register support is built in when MS_SYNC_TIMESTAMP_EN is defined (see ms_sync_regs).
module ms_sync_gen
  import ms_sync_pkg::*;
#(
  parameter logic [15:0] DEF_PERIOD_MS = DEFAULT_PERIOD_MS,
  parameter logic [15:0] DEF_PULSE_MS  = DEFAULT_PULSE_MS,
  parameter logic [3:0]  DEF_N_PULSES  = DEFAULT_N_PULSES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        sync_out,
  output logic        master_sync_out,
  output logic        irq
);

  sync_state_e state_q, state_d;
  logic        tick_prev_q, tick_prev_d;
  logic        tick_rise;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] eff_period_q, eff_period_d;
  logic [15:0] eff_pulse_q, eff_pulse_d;
  logic [3:0]  eff_n_q, eff_n_d;
  logic        sync_q, sync_d;
  logic        master_q, master_d;
  logic        load;
  logic        wrap;
  logic        start_stb;
  logic        stop_stb;
  logic [15:0] period_ms;
  logic [15:0] pulse_ms;
  logic [3:0]  n_pulses;
  logic        one_shot;
  logic        running;

  ms_sync_regs #(
    .DEF_PERIOD_MS (DEF_PERIOD_MS),
    .DEF_PULSE_MS  (DEF_PULSE_MS),
    .DEF_N_PULSES  (DEF_N_PULSES)
  ) u_regs (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .running     (running),
    .pulse_entry (load),
    .tick_rise   (tick_rise),
    .start_stb   (start_stb),
    .stop_stb    (stop_stb),
    .period_ms   (period_ms),
    .pulse_ms    (pulse_ms),
    .n_pulses    (n_pulses),
    .one_shot    (one_shot),
    .irq         (irq)
  );

  assign tick_prev_d = tick_in;
  assign tick_rise   = tick_in & ~tick_prev_q;
  assign running     = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    ms_cnt_d     = ms_cnt_q;
    idx_d        = idx_q;
    eff_period_d = eff_period_q;
    eff_pulse_d  = eff_pulse_q;
    eff_n_d      = eff_n_q;
    load         = 1'b0;
    wrap         = 1'b0;
    case (state_q)
      ST_PULSE: begin
        if (tick_rise) begin
          ms_cnt_d = ms_cnt_q + 16'd1;
          if (ms_cnt_q == eff_pulse_q - 16'd1) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick_rise) begin
          if (ms_cnt_q == eff_period_q - 16'd1) begin
            // >= keeps the index bounded if NPULSE shrank since the sequence began.
            wrap     = (idx_q >= eff_n_q - 4'd1);
            ms_cnt_d = 16'd0;
            idx_d    = wrap ? 4'd0 : idx_q + 4'd1;
            if (wrap && one_shot) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_PULSE;
              load    = 1'b1;
            end
          end else begin
            ms_cnt_d = ms_cnt_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
    if (start_stb) begin
      state_d  = ST_PULSE;
      ms_cnt_d = 16'd0;
      idx_d    = 4'd0;
      load     = 1'b1;
    end
    if (stop_stb) begin
      state_d = ST_IDLE;
      load    = 1'b0;
    end
    // Timing registers are sampled only here so a running cycle is never retimed.
    if (load) begin
      eff_period_d = clamp_period(period_ms);
      eff_pulse_d  = clamp_pulse(pulse_ms, eff_period_d);
      eff_n_d      = clamp_n(n_pulses);
    end
    sync_d   = (state_q == ST_PULSE);
    master_d = (state_q == ST_PULSE) && (idx_q == 4'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tick_prev_q  <= 1'b0;
      ms_cnt_q     <= 16'd0;
      idx_q        <= 4'd0;
      eff_period_q <= 16'd0;
      eff_pulse_q  <= 16'd0;
      eff_n_q      <= 4'd0;
      sync_q       <= 1'b0;
      master_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_prev_q  <= tick_prev_d;
      ms_cnt_q     <= ms_cnt_d;
      idx_q        <= idx_d;
      eff_period_q <= eff_period_d;
      eff_pulse_q  <= eff_pulse_d;
      eff_n_q      <= eff_n_d;
      sync_q       <= sync_d;
      master_q     <= master_d;
    end
  end

  assign sync_out        = sync_q;
  assign master_sync_out = master_q;

endmodule
